// File: rtl/router_pkg.sv
// Shared router definitions: requester indices, VC numbering, per-VC FSM states
// and a small one-hot decode helper.
package router_pkg;

  localparam int REQ_PE = 0;
  localparam int REQ_WE = 1;
  localparam int REQ_S  = 2;
  localparam int REQ_N  = 3;

  localparam logic VC_EVEN = 1'b0;
  localparam logic VC_ODD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FULL  = 2'd2
  } vc_state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/vc_output_scheduler_if.sv
// Handshake bundle between input-port requesters and one output-port scheduler.
interface vc_output_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int NUM_VC  = 2
);
  logic               polarity;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_vc;
  logic [NUM_VC-1:0]  buf_empty;
  logic [NUM_REQ-1:0] grant;
  logic               grant_vc;
  logic               load;
  logic [NUM_REQ-1:0] clear;
  logic [NUM_VC-1:0]  busy;

  modport master (
    output polarity, req, req_vc, buf_empty,
    input  grant, grant_vc, load, clear, busy
  );

  modport slave (
    input  polarity, req, req_vc, buf_empty,
    output grant, grant_vc, load, clear, busy
  );
endinterface

// File: rtl/vc_output_scheduler_chk.sv
// Output-invariant checker bound alongside the scheduler.
module vc_output_scheduler_chk #(
  parameter int NUM_REQ = 4,
  parameter int NUM_VC  = 2
) (
  input logic               clk,
  input logic               reset,
  input logic [NUM_REQ-1:0] grant,
  input logic [NUM_REQ-1:0] clear,
  input logic               load,
  input logic               grant_vc,
  input logic [NUM_VC-1:0]  busy,
  input logic [NUM_VC-1:0]  not_idle
);

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
  a_clear_eq:     assert property (@(posedge clk) disable iff (reset) clear == grant);
  a_load_eq:      assert property (@(posedge clk) disable iff (reset) load == (|grant));
  a_vc_quiet:     assert property (@(posedge clk) disable iff (reset) !load |-> !grant_vc);
  a_busy_fsm:     assert property (@(posedge clk) disable iff (reset) busy == not_idle);

endmodule

// File: rtl/vc_output_scheduler_rr_select.sv
// Round-robin pick: first set request at or after ptr, ascending with wrap 3->0.
module rr_select (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] winner,
  output logic       valid
);

  logic [1:0] idx_s;

  // scan the four slots starting at the pointer; first hit wins
  always_comb begin
    winner = 4'b0000;
    valid  = 1'b0;
    idx_s  = ptr;
    for (int k = 0; k < 4; k++) begin
      idx_s = ptr + 2'(k);
      if (!valid && req[idx_s]) begin
        winner[idx_s] = 1'b1;
        valid         = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/vc_output_scheduler.sv
// Per-VC issue scheduler for one router output port: polarity-phased round-robin
// arbitration into the even/odd output buffers, with registered grant/load/clear.
module vc_output_scheduler
  import router_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_VC  = 2
) (
  input logic                  clk,
  input logic                  reset,
  vc_output_scheduler_if.slave bus
);

  vc_state_e          state_r     [NUM_VC];
  vc_state_e          state_nx_s  [NUM_VC];
  logic [1:0]         ptr_r       [NUM_VC];
  logic [1:0]         ptr_nx_s    [NUM_VC];
  logic [NUM_REQ-1:0] elig_s      [NUM_VC];
  logic [NUM_REQ-1:0] win_s       [NUM_VC];
  logic [NUM_VC-1:0]  win_valid_s;
  logic [NUM_VC-1:0]  not_idle_s;

  logic [NUM_REQ-1:0] grant_nx_s, grant_r;
  logic               load_nx_s, load_r;
  logic               vc_nx_s, grant_vc_r;
  logic [NUM_VC-1:0]  busy_nx_s, busy_r;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    localparam logic VC_BIT = (v == 1);
    // a VC only arbitrates in its own phase, from IDLE, into an empty buffer
    assign elig_s[v] = bus.req & (VC_BIT ? bus.req_vc : ~bus.req_vc)
                     & {NUM_REQ{bus.buf_empty[v] & (state_r[v] == ST_IDLE)
                                & (bus.polarity == VC_BIT)}};
    assign not_idle_s[v] = (state_r[v] != ST_IDLE);

    rr_select u_rr (
      .req    (elig_s[v]),
      .ptr    (ptr_r[v]),
      .winner (win_s[v]),
      .valid  (win_valid_s[v])
    );
  end

  // per-VC next state and pointer
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      state_nx_s[v] = state_r[v];
      ptr_nx_s[v]   = ptr_r[v];
      case (state_r[v])
        ST_IDLE: begin
          if (win_valid_s[v]) begin
            state_nx_s[v] = ST_ISSUE;
            ptr_nx_s[v]   = onehot_to_idx(win_s[v]) + 2'd1;
          end else begin
            state_nx_s[v] = ST_IDLE;
          end
        end
        ST_ISSUE: state_nx_s[v] = ST_FULL;
        ST_FULL: begin
          if (bus.buf_empty[v]) begin
            state_nx_s[v] = ST_IDLE;
          end else begin
            state_nx_s[v] = ST_FULL;
          end
        end
        default: state_nx_s[v] = ST_IDLE;
      endcase
    end
  end

  // issue outputs; polarity guarantees at most one VC wins per edge
  always_comb begin
    grant_nx_s = {NUM_REQ{1'b0}};
    load_nx_s  = 1'b0;
    vc_nx_s    = 1'b0;
    busy_nx_s  = {NUM_VC{1'b0}};
    for (int v = 0; v < NUM_VC; v++) begin
      grant_nx_s   = grant_nx_s | win_s[v];
      load_nx_s    = load_nx_s | win_valid_s[v];
      vc_nx_s      = vc_nx_s | (win_valid_s[v] & (v == 1));
      busy_nx_s[v] = (state_nx_s[v] != ST_IDLE);
    end
  end

  // state, pointer and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        state_r[v] <= ST_IDLE;
        ptr_r[v]   <= 2'd0;
      end
      grant_r    <= {NUM_REQ{1'b0}};
      load_r     <= 1'b0;
      grant_vc_r <= 1'b0;
      busy_r     <= {NUM_VC{1'b0}};
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        state_r[v] <= state_nx_s[v];
        ptr_r[v]   <= ptr_nx_s[v];
      end
      grant_r    <= grant_nx_s;
      load_r     <= load_nx_s;
      grant_vc_r <= vc_nx_s;
      busy_r     <= busy_nx_s;
    end
  end

  assign bus.grant    = grant_r;
  assign bus.clear    = grant_r;
  assign bus.load     = load_r;
  assign bus.grant_vc = grant_vc_r;
  assign bus.busy     = busy_r;

  vc_output_scheduler_chk #(.NUM_REQ(NUM_REQ), .NUM_VC(NUM_VC)) u_chk (
    .clk      (clk),
    .reset    (reset),
    .grant    (grant_r),
    .clear    (grant_r),
    .load     (load_r),
    .grant_vc (grant_vc_r),
    .busy     (busy_r),
    .not_idle (not_idle_s)
  );

endmodule

// File: tb/tb_vc_output_scheduler.sv
// Randomized + directed bench for vc_output_scheduler against a queue-free
// per-VC behavioural model.
module tb_vc_output_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vc_output_scheduler_if #(.NUM_REQ(4), .NUM_VC(2)) bus_if ();

  vc_output_scheduler #(.NUM_REQ(4), .NUM_VC(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_chk = 0;
  int n_bad = 0;

  // model: phase per VC (0 waiting, 1 loading, 2 buffer occupied), next start index
  int         m_phase [2];
  int         m_next  [2];
  logic [3:0] e_grant;
  logic       e_load;
  logic       e_vc;
  logic [1:0] e_busy;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 2; v++) begin
      m_phase[v] = 0;
      m_next[v]  = 0;
    end
    e_grant = 4'b0000;
    e_load  = 1'b0;
    e_vc    = 1'b0;
    e_busy  = 2'b00;
  endtask

  // evaluate what the coming rising edge does with the inputs now applied
  task automatic model_step();
    e_grant = 4'b0000;
    e_load  = 1'b0;
    e_vc    = 1'b0;
    for (int v = 0; v < 2; v++) begin
      if (m_phase[v] == 0) begin
        if (int'(bus_if.polarity) == v && bus_if.buf_empty[v]) begin
          for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_next[v] + k) % 4;
            if (m_phase[v] == 0 && bus_if.req[i] && int'(bus_if.req_vc[i]) == v) begin
              m_phase[v] = 1;
              m_next[v]  = (i + 1) % 4;
              e_grant    = 4'(1 << i);
              e_load     = 1'b1;
              e_vc       = (v == 1);
            end
          end
        end
      end else if (m_phase[v] == 1) begin
        m_phase[v] = 2;
      end else if (bus_if.buf_empty[v]) begin
        m_phase[v] = 0;
      end
      e_busy[v] = (m_phase[v] != 0);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, "_grant"}, 8'(bus_if.grant),    8'(e_grant));
    check_val({tag, "_clear"}, 8'(bus_if.clear),    8'(e_grant));
    check_val({tag, "_load"},  8'(bus_if.load),     8'(e_load));
    check_val({tag, "_vc"},    8'(bus_if.grant_vc), 8'(e_vc));
    check_val({tag, "_busy"},  8'(bus_if.busy),     8'(e_busy));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic pol, input logic [3:0] r, input logic [3:0] rv, input logic [1:0] be);
    bus_if.polarity  = pol;
    bus_if.req       = r;
    bus_if.req_vc    = rv;
    bus_if.buf_empty = be;
  endtask

  task automatic do_reset();
    set_in(1'b0, 4'b0000, 4'b0000, 2'b11);
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    set_in(1'b0, 4'b0000, 4'b0000, 2'b11);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // single PE request on the even VC
    set_in(1'b0, 4'b0001, 4'b0000, 2'b11);
    tick("first");
    check_val("first_grant", 8'(bus_if.grant), 8'h01);
    check_val("first_busy0", 8'(bus_if.busy[0]), 8'h01);
    set_in(1'b1, 4'b0000, 4'b0000, 2'b11);
    tick("first_tail");

    // full contention on VC0, buffer drains two cycles after each load
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(1'b0, 4'b1111, 4'b0000, 2'b11);
      tick("rr");
      check_val("rr_seq", 8'(bus_if.grant), 8'(1 << (k % 4)));
      bus_if.buf_empty = 2'b10;
      tick("rr_full");
      tick("rr_full");
      bus_if.buf_empty = 2'b11;
      tick("rr_drain");
    end

    // mixed VCs with alternating phase
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_in(c[0], 4'b0011, 4'b0010, 2'b11);
      tick("alt");
      if (c == 0) check_val("alt_vc0", 8'(bus_if.grant), 8'h01);
      if (c == 1) check_val("alt_vc1", 8'(bus_if.grant), 8'h02);
    end

    // VC0 buffer occupied blocks even requests
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(1'b0, 4'b0100, 4'b0000, 2'b10);
      tick("blocked");
    end
    check_val("blocked_load", 8'(bus_if.load), 8'h00);
    bus_if.buf_empty = 2'b11;
    tick("unblocked");
    check_val("unblocked_grant", 8'(bus_if.grant), 8'h04);

    // reset mid-ISSUE truncates the pulse asynchronously
    do_reset();
    set_in(1'b0, 4'b1110, 4'b0000, 2'b11);
    tick("pre_rst");
    #2;
    reset = 1'b1;
    #1;
    check_val("rst_grant", 8'(bus_if.grant), 8'h00);
    check_val("rst_load",  8'(bus_if.load),  8'h00);
    check_val("rst_clear", 8'(bus_if.clear), 8'h00);
    check_val("rst_busy",  8'(bus_if.busy),  8'h00);
    model_reset();
    set_in(1'b0, 4'b0000, 4'b0000, 2'b11);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick("post_rst_idle");
    set_in(1'b0, 4'b1010, 4'b0000, 2'b11);
    tick("post_rst");
    check_val("post_rst_grant", 8'(bus_if.grant), 8'h02);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 800; c++) begin
      logic pol;
      pol = c[0];
      if ($urandom_range(0, 7) == 0) pol = ~pol;
      set_in(pol, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)});
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
